axis_packet_buffer: RTL
=======================

AXIS_PACKET_BUFFER -- requirements
Module: axis_packet_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: tdata width in bits; SHALL be a multiple of 8, 8..1024.
REQ-002 Parameter DEPTH, default 16: buffer entries; SHALL be a power of 2, 2..1024.
REQ-003 Parameter PACKET_MODE, default 0: 0 = cut-through streaming; 1 = store-and-forward on tlast.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 axis_aclk  in  1  clock; all logic on rising edge.
REQ-006 axis_areset  in  1  synchronous active-high reset.
REQ-007 s01_axis_tdata  in  DATA_WIDTH  slave data.
REQ-008 s01_axis_tstrb  in  DATA_WIDTH/8  slave byte strobes; stored with data.
REQ-009 s01_axis_tvalid  in  1  slave beat valid.
REQ-010 s01_axis_tlast  in  1  slave end of packet; stored with data.
REQ-011 s01_axis_tready  out  1  buffer can accept a beat.
REQ-012 m01_axis_tdata  out  DATA_WIDTH  master data.
REQ-013 m01_axis_tstrb  out  DATA_WIDTH/8  master byte strobes.
REQ-014 m01_axis_tvalid  out  1  master beat valid.
REQ-015 m01_axis_tlast  out  1  master end of packet.
REQ-016 m01_axis_tready  in  1  downstream accepts beat.
REQ-017 fill_count  out  $clog2(DEPTH)+1  entries currently stored.
REQ-018 pkt_count  out  $clog2(DEPTH)+1  complete packets (tlast beats) stored.

Function
REQ-019 Storage SHALL be a DEPTH-entry circular buffer of {tdata, tstrb, tlast} with write and read pointers wrapping from DEPTH-1 to 0.
REQ-020 Write SHALL occur on a cycle where s01_axis_tvalid && s01_axis_tready; read where m01_axis_tvalid && m01_axis_tready.
REQ-021 s01_axis_tready SHALL equal (fill_count != DEPTH) && !axis_areset, combinationally.
REQ-022 Output SHALL be first-word-fall-through: m01_axis_tdata/tstrb/tlast SHALL present the entry at the read pointer whenever m01_axis_tvalid is 1.
REQ-023 Latency: a beat written into an empty buffer SHALL be visible on the master port in the next cycle (PACKET_MODE=0), never in the same cycle.
REQ-024 PACKET_MODE=0: m01_axis_tvalid SHALL equal (fill_count != 0).
REQ-025 PACKET_MODE=1: m01_axis_tvalid SHALL equal (pkt_count != 0) || (fill_count == DEPTH) || draining.
REQ-026 PACKET_MODE=1 SHALL use a two-state output FSM, IDLE and DRAIN: IDLE->DRAIN when a read occurs with m01_axis_tlast=0; DRAIN->IDLE when a read occurs with m01_axis_tlast=1; draining = (state == DRAIN) && fill_count != 0.
REQ-027 The full-with-no-complete-packet case (REQ-025) SHALL release the oversize packet in cut-through fashion to prevent deadlock.
REQ-028 fill_count SHALL increment on write only, decrement on read only, and hold on simultaneous write and read.
REQ-029 pkt_count SHALL increment on a write with tlast=1, decrement on a read with tlast=1, and hold when both occur in one cycle.
REQ-030 Simultaneous write and read when fill_count = DEPTH-1 or 1 SHALL be legal and lossless.
REQ-031 When m01_axis_tvalid=1 and m01_axis_tready=0, master outputs SHALL hold stable (AXI-Stream rule).
REQ-032 tstrb SHALL pass through unmodified; a beat with tstrb=0 SHALL still be stored and forwarded.
REQ-033 When m01_axis_tvalid=0, m01_axis_tdata/tstrb/tlast SHALL be driven to 0, never X or Z.

Reset
REQ-034 While axis_areset=1 on a rising edge, the block SHALL clear pointers, fill_count=0, pkt_count=0, and FSM=IDLE.
REQ-035 During and after reset: s01_axis_tready=0 while reset is high; m01_axis_tvalid=0, tdata=0, tstrb=0, tlast=0.
REQ-036 Reset asserted mid-packet SHALL discard all stored beats; no beat stored before reset appears afterwards.
REQ-037 Memory contents need not be cleared.

Verification
REQ-038 Configuration PACKET_MODE=0, DEPTH=4: write 4 beats 0xA0..0xA3 with m01_axis_tready=0 -> s01_axis_tready=0 after the 4th, fill_count=4; release ready -> 0xA0..0xA3 in order, one per cycle.
REQ-039 Configuration PACKET_MODE=0: continuous tvalid/tready for 100 beats -> throughput of 1 beat/cycle, fill_count constant at 1, data in order.
REQ-040 Configuration PACKET_MODE=1, DEPTH=16: write a 3-beat packet with tlast on the 3rd -> m01_axis_tvalid stays 0 until the cycle after the tlast write, then 3 beats with tlast on the 3rd; pkt_count 1->0.
REQ-041 Configuration PACKET_MODE=1, DEPTH=4: send a 6-beat packet -> at fill_count=4 m01_axis_tvalid=1, all 6 beats emerge in order, tlast only on the 6th, and the FSM returns to IDLE.
REQ-042 Scenario: write tstrb=4'b0101 and tdata=0xDEADBEEF, and apply random m01_axis_tready backpressure -> output matches exactly and outputs stay stable while stalled.
REQ-043 Scenario: assert reset with fill_count=3 -> the next cycle has fill_count=0 and m01_axis_tvalid=0; a new beat 0x55 written afterwards is the first one output.

Source files
------------

// File: rtl/axis_packet_buffer.sv
// axis_packet_buffer: AXI-Stream buffer with first-word-fall-through output.
// PACKET_MODE=0 streams beats through as soon as they are stored.
// PACKET_MODE=1 holds beats until a whole packet (tlast) is stored. An oversize
// packet that fills the buffer is released cut-through so the buffer cannot deadlock.
module axis_packet_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0
) (
    input  logic                      axis_aclk,
    input  logic                      axis_areset,
    input  logic [DATA_WIDTH-1:0]     s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s01_axis_tstrb,
    input  logic                      s01_axis_tvalid,
    input  logic                      s01_axis_tlast,
    output logic                      s01_axis_tready,
    output logic [DATA_WIDTH-1:0]     m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m01_axis_tstrb,
    output logic                      m01_axis_tvalid,
    output logic                      m01_axis_tlast,
    input  logic                      m01_axis_tready,
    output logic [$clog2(DEPTH):0]    fill_count,
    output logic [$clog2(DEPTH):0]    pkt_count
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + SW + 1;

    localparam logic [AW-1:0] PTR_ZERO = AW'(32'd0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(32'd1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Output FSM: DRAIN means a packet has started leaving and must finish.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Storage entry layout: {tlast, tstrb, tdata}
    logic [EW-1:0]         r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_fill;
    logic [CW-1:0]         r_pkt;
    state_t                r_state;

    state_t                w_state_nxt;
    logic [CW-1:0]         w_fill_nxt;
    logic [CW-1:0]         w_pkt_nxt;
    logic [EW-1:0]         w_head;
    logic                  w_head_last;
    logic [SW-1:0]         w_head_strb;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_draining;
    logic                  w_valid;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_pkt_in;
    logic                  w_pkt_out;

    assign w_full      = (r_fill == CNT_FULL);
    assign w_empty     = (r_fill == CNT_ZERO);
    assign w_draining  = (r_state == ST_DRAIN) && !w_empty;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_last = w_head[EW-1];
    assign w_head_strb = w_head[EW-2 -: SW];
    assign w_head_data = w_head[DATA_WIDTH-1:0];

    assign s01_axis_tready = !w_full && !axis_areset;
    assign w_wr_en   = s01_axis_tvalid && s01_axis_tready;
    assign w_rd_en   = w_valid && m01_axis_tready;
    assign w_pkt_in  = w_wr_en && s01_axis_tlast;
    assign w_pkt_out = w_rd_en && w_head_last;

    assign m01_axis_tvalid = w_valid;
    assign fill_count      = r_fill;
    assign pkt_count       = r_pkt;

    // Decide whether the head entry may be offered downstream in this mode.
    always_comb begin
        w_valid = 1'b0;
        if (axis_areset) begin
            w_valid = 1'b0;
        end else if (PACKET_MODE != 32'sd0) begin
            w_valid = (r_pkt != CNT_ZERO) || w_full || w_draining;
        end else begin
            w_valid = !w_empty;
        end
    end

    // Present the head entry while valid, otherwise hold the master bus at zero.
    always_comb begin
        m01_axis_tdata = {DATA_WIDTH{1'b0}};
        m01_axis_tstrb = {SW{1'b0}};
        m01_axis_tlast = 1'b0;
        if (w_valid) begin
            m01_axis_tdata = w_head_data;
            m01_axis_tstrb = w_head_strb;
            m01_axis_tlast = w_head_last;
        end else begin
            m01_axis_tdata = {DATA_WIDTH{1'b0}};
            m01_axis_tstrb = {SW{1'b0}};
            m01_axis_tlast = 1'b0;
        end
    end

    // Occupancy: a simultaneous write and read leaves the count unchanged.
    always_comb begin
        w_fill_nxt = r_fill;
        case ({w_wr_en, w_rd_en})
            2'b10:   w_fill_nxt = r_fill + CNT_ONE;
            2'b01:   w_fill_nxt = r_fill - CNT_ONE;
            default: w_fill_nxt = r_fill;
        endcase
    end

    // Complete-packet count: tlast beats in minus tlast beats out.
    always_comb begin
        w_pkt_nxt = r_pkt;
        case ({w_pkt_in, w_pkt_out})
            2'b10:   w_pkt_nxt = r_pkt + CNT_ONE;
            2'b01:   w_pkt_nxt = r_pkt - CNT_ONE;
            default: w_pkt_nxt = r_pkt;
        endcase
    end

    // Output FSM next state: enter DRAIN on a non-last read, leave on a last read.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_en && !w_head_last) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (w_rd_en && w_head_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Store accepted beats; contents are not cleared by reset.
    always_ff @(posedge axis_aclk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= {s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata};
        end
    end

    // Pointers, counters and FSM state; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_fill   <= CNT_ZERO;
            r_pkt    <= CNT_ZERO;
            r_state  <= ST_IDLE;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_fill  <= w_fill_nxt;
            r_pkt   <= w_pkt_nxt;
            r_state <= w_state_nxt;
        end
    end

endmodule
